// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared FSM encoding and width helpers for the FIFO write arbiter
package fifo_wr_arbiter_pkg;

  // Two-state grant FSM; kept as plain 1-bit constants for older tools
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  // Index width for a requester number; at least one bit so NREQ=1 stays legal
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width: wide enough to hold MAX_BURST-1 with one spare bit
  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer-side and FIFO-write-side signal bundle for the arbiter
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) ();

  localparam int IW = idx_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_din;
  logic [IW-1:0]      owner;
  logic               busy;

  // Arbiter side
  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, owner, busy
  );

  // Producers and FIFO side
  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, owner, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - rotating-priority encoder starting just after last_owner
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last_owner,
  output logic [IW-1:0]   winner,
  output logic            any_valid
);

  logic [IW-1:0] cand;

  // Scan from the farthest candidate back to last_owner+1 so the nearest valid one wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_owner) + k) % NREQ);
      if (valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter sharing one FIFO write port among NREQ producers
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input logic         clk,
  input logic         rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = cnt_w(MAX_BURST);

  logic [0:0]      state;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_owner;
  logic [BW-1:0]   beat_cnt;

  logic [IW-1:0]   winner;
  logic            any_valid;
  logic            own_valid;
  logic            own_last;
  logic [DW-1:0]   own_data;
  logic [NREQ-1:0] ready;
  logic            in_burst;
  logic            xfer;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .valid      (bus.req_valid),
    .last_owner (last_owner),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Select the current owner's valid/last/data from the flattened request buses
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign in_burst = (state == BURST);
  assign xfer     = in_burst && own_valid && !bus.fifo_full;

  // Only the owner sees ready, and only while the FIFO has room
  always_comb begin
    ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in_burst && owner_q == IW'(i)) ready[i] = !bus.fifo_full;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = in_burst ? own_data : '0;
  assign bus.owner      = in_burst ? owner_q : '0;
  assign bus.busy       = in_burst;

  // Grant FSM: pick a winner in IDLE, hold it until last beat or the burst cap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_q    <= '0;
      last_owner <= IW'(NREQ - 1);
      beat_cnt   <= '0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        owner_q  <= winner;
        beat_cnt <= '0;
        state    <= BURST;
      end
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (own_last || beat_cnt == BW'(MAX_BURST - 1)) begin
        last_owner <= owner_q;
        state      <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed scoreboard bench for fifo_wr_arbiter and its rr_pick encoder
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   cyc;

  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] pick_valid;
  logic [1:0] pick_last;
  logic [1:0] pick_winner;
  logic       pick_any;

  fifo_wr_arbiter_rr_pick #(.NREQ(4), .IW(2)) u_pick (
    .valid      (pick_valid),
    .last_owner (pick_last),
    .winner     (pick_winner),
    .any_valid  (pick_any)
  );

  // producer beat queues {last, data} and expected FIFO writes {src, data}
  logic [8:0]  pq [4][$];
  logic [10:0] sb [$];

  logic gap_chk;
  logic have_prev;
  int   prev_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO-side monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.fifo_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.fifo_din), 32'hFFFF_FFFF);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        check("fifo_din", 32'(bus.fifo_din), 32'(e[7:0]));
        check("write_owner", 32'(bus.owner), 32'(e[10:8]));
      end
      if (gap_chk) begin
        if (have_prev) check("write_gap", 32'(cyc - prev_cyc), 32'd2);
        have_prev = 1'b1;
        prev_cyc  = cyc;
      end
    end
    if (!gap_chk) have_prev = 1'b0;
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pq[i].size() > 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*8 +: 8]  = pq[i][0][7:0];
        bus.req_last[i]         = pq[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*8 +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = bus.req_ready & bus.req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
    drive();
  endtask

  task automatic beat(input int src, input logic [7:0] d, input logic last);
    pq[src].push_back({last, d});
  endtask

  task automatic expect_wr(input int src, input logic [7:0] d);
    sb.push_back({3'(src), d});
  endtask

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0) && (bus.busy === 1'b0);
    for (int i = 0; i < 4; i++) if (pq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(all_idle()), 32'd1);
  endtask

  task automatic flush_producers();
    for (int i = 0; i < 4; i++) pq[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_producers();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'd0);
    check({tag, "_owner"}, 32'(bus.owner), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  logic [3:0] tab_valid [7] = '{4'b0000, 4'b1010, 4'b0001, 4'b0110, 4'b1111, 4'b1111, 4'b0100};
  logic [1:0] tab_last  [7] = '{2'd3,    2'd1,    2'd3,    2'd2,    2'd3,    2'd0,    2'd2};
  logic [1:0] tab_win   [7] = '{2'd0,    2'd3,    2'd0,    2'd1,    2'd0,    2'd1,    2'd2};
  logic       tab_any   [7] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    gap_chk      = 1'b0;
    have_prev    = 1'b0;
    prev_cyc     = 0;
    rst          = 1'b0;
    bus.fifo_full = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    pick_valid    = '0;
    pick_last     = '0;

    // rotating-priority encoder on its own
    for (int t = 0; t < 7; t++) begin
      pick_valid = tab_valid[t];
      pick_last  = tab_last[t];
      #1;
      check($sformatf("pick_winner_%0d", t), 32'(pick_winner), 32'(tab_win[t]));
      check($sformatf("pick_any_%0d", t), 32'(pick_any), 32'(tab_any[t]));
    end

    // reset, then idle with no requests
    @(negedge clk);
    check_quiet("in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin
      step();
      check_quiet("idle");
    end

    // single 3-beat packet from requester 2
    beat(2, 8'hA1, 1'b0); beat(2, 8'hA2, 1'b0); beat(2, 8'hA3, 1'b1);
    expect_wr(2, 8'hA1); expect_wr(2, 8'hA2); expect_wr(2, 8'hA3);
    drive();
    step();
    check("single_owner0", 32'(bus.owner), 32'd2);
    check("single_busy0", 32'(bus.busy), 32'd1);
    step();
    check("single_owner1", 32'(bus.owner), 32'd2);
    step();
    check("single_owner2", 32'(bus.owner), 32'd2);
    check("single_busy2", 32'(bus.busy), 32'd1);
    step();
    check("single_busy_drop", 32'(bus.busy), 32'd0);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // round-robin with every requester continuously valid
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        beat(i, 8'(8'h10 + i), 1'b1);
        expect_wr(i, 8'(8'h10 + i));
      end
    end
    gap_chk = 1'b1;
    drive();
    drain("rr_drain", 200);
    gap_chk = 1'b0;

    // backpressure in the middle of a 4-beat packet from requester 1
    beat(1, 8'hB1, 1'b0); beat(1, 8'hB2, 1'b0); beat(1, 8'hB3, 1'b0); beat(1, 8'hB4, 1'b1);
    expect_wr(1, 8'hB1); expect_wr(1, 8'hB2); expect_wr(1, 8'hB3); expect_wr(1, 8'hB4);
    drive();
    step();
    check("bp_owner_grant", 32'(bus.owner), 32'd1);
    step();
    step();
    for (int t = 0; t < 3; t++) begin
      bus.fifo_full = 1'b1;
      #1;
      check("bp_stall_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("bp_stall_ready1", 32'(bus.req_ready[1]), 32'd0);
      check("bp_stall_owner", 32'(bus.owner), 32'd1);
      step();
    end
    bus.fifo_full = 1'b0;
    drain("bp_drain", 100);

    // burst cap splits a 6-beat packet around requester 3's packet
    do_reset();
    for (int b = 1; b <= 6; b++) beat(0, 8'(8'hC0 + b), (b == 6));
    beat(3, 8'hD1, 1'b0); beat(3, 8'hD2, 1'b1);
    for (int b = 1; b <= 4; b++) expect_wr(0, 8'(8'hC0 + b));
    expect_wr(3, 8'hD1); expect_wr(3, 8'hD2);
    expect_wr(0, 8'hC5); expect_wr(0, 8'hC6);
    drive();
    drain("cap_drain", 100);

    // reset asserted after beat 2 of a 4-beat packet from requester 3
    beat(3, 8'hE1, 1'b0); beat(3, 8'hE2, 1'b0); beat(3, 8'hE3, 1'b0); beat(3, 8'hE4, 1'b1);
    expect_wr(3, 8'hE1); expect_wr(3, 8'hE2);
    drive();
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    check_quiet("midrst");
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    flush_producers();
    beat(3, 8'hF1, 1'b1);
    beat(0, 8'h61, 1'b1);
    expect_wr(0, 8'h61);
    expect_wr(3, 8'hF1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("midrst_first_owner", 32'(bus.owner), 32'd0);
    drain("midrst_drain", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NREQ producers share one 8-bit-wide FIFO write port.
- Grants one requester at a time and holds the grant for a packet of up to MAX_BURST beats, so packet beats from one source land contiguously in the FIFO.
- Sits between the producer blocks and the FIFO write side (wr_en/din/full); does not touch the read side.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- MAX_BURST, 4, maximum beats per grant before forced release (1..16).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DW  per-requester beat data; requester i uses bits [DW*i +: DW].
- req_last  in  NREQ  per-requester last-beat-of-packet flag.
- req_ready  out  NREQ  per-requester beat accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  DW  FIFO write data.
- owner  out  clog2(NREQ)  index of the current grant holder; 0 when idle.
- busy  out  1  high while in BURST.

Behaviour:
- Reset:
  - State goes to IDLE, owner=0, beat_cnt=0, last_owner=NREQ-1 (requester 0 has first priority).
  - All outputs are 0 during reset and on the first cycle after release.
- Reset asserted mid-burst aborts the burst immediately. No write is issued, and the partial packet already in the FIFO is left as is.
- FSM, two states:
  - IDLE:
    - busy=0, req_ready=0, fifo_wr_en=0.
    - If any req_valid is high, register owner = the first valid index searching last_owner+1, last_owner+2, ... mod NREQ.
    - Clear beat_cnt and go to BURST.
    - This costs one arbitration bubble cycle per grant.
  - BURST:
    - busy=1.
    - req_ready[owner] = !fifo_full; every other req_ready is 0.
    - fifo_wr_en = req_valid[owner] && !fifo_full.
    - fifo_din = req_data[owner].
    - On each transfer, beat_cnt increments.
    - If the transfer has req_last[owner]=1 or beat_cnt==MAX_BURST-1, then: last_owner<=owner, go to IDLE.
- Output path: fifo_wr_en, fifo_din and req_ready are combinational from registered state plus the current inputs. Data written = data presented in the same cycle.
- Backpressure: while fifo_full=1 no transfer occurs and beat_cnt holds. The grant is never revoked because of full.
- Owner deasserting valid mid-packet: the grant is held indefinitely and no other requester is served. Producers must not stall mid-packet.
- Forced release at MAX_BURST: the remaining beats of that packet rejoin arbitration as a new grant. The FIFO then holds that packet non-contiguously, which is documented producer-visible behaviour.
- Fairness: with all requesters continuously valid and single-beat packets, the grant order is 0,1,2,3,0,... with one write every 2 cycles.
- Requests from non-owners are ignored; req_valid may change freely while not ready.
- beat_cnt is clog2(MAX_BURST)+1 bits wide. last_owner+k wraps modulo NREQ, including when NREQ is not a power of two.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=1'b0, BURST=1'b1;
  - width helper constants derived via clog2.
- One sub-module, rr_pick: a combinational rotating-priority encoder.
  - Inputs: valid vector, last_owner.
  - Outputs: winner index, any_valid.
  - Instantiated once; unit-tested separately.

Test Plan:
- Reset then idle:
  - Stimulus: rst low for 2 cycles, release, no req_valid.
  - Required: busy=0, fifo_wr_en=0, owner=0, req_ready=0 for 10 cycles.
- Single packet:
  - Stimulus: req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3; fifo_full=0.
  - Required: owner=2 from cycle 2; 3 consecutive writes of A1,A2,A3; busy drops the cycle after A3.
- Round-robin:
  - Stimulus: all 4 requesters valid, single-beat packets with data 0x10+i, held valid.
  - Required: FIFO receives 10,11,12,13,10,... with one write every 2 cycles.
- Backpressure:
  - Stimulus: req 1 sends a 4-beat packet; fifo_full is forced high for 3 cycles after beat 2.
  - Required: no fifo_wr_en and req_ready[1]=0 during the stall; beats 3 and 4 are written afterwards in order; owner stays 1 throughout.
- Burst cap:
  - Stimulus: MAX_BURST=4; req 0 sends 6 beats with last on beat 6; req 3 is also valid.
  - Required: 4 beats from req 0, then req 3's packet, then req 0's remaining 2 beats.
- Reset mid-burst:
  - Stimulus: assert rst after beat 2 of a 4-beat packet from req 3.
  - Required: fifo_wr_en=0 immediately; after release requester 0 wins first if valid.
